// File: rtl/unidade_controle_exp6_pkg.sv
// rtl/unidade_controle_exp6_pkg.sv - state codes, output bundle and default timing for the game controller
package unidade_controle_exp6_pkg;

  localparam int T_LED_DEF     = 500;
  localparam int T_APAGA_DEF   = 250;
  localparam int T_TIMEOUT_DEF = 5000;
  localparam int TIMER_W       = 16;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    PROX_MOSTRA = 4'h4,
    ZERA_JOG    = 4'h5,
    ESPERA      = 4'h6,
    REGISTRA    = 4'h7,
    COMPARA     = 4'h8,
    PROX_JOG    = 4'h9,
    PROX_RODADA = 4'hA,
    FIM_ACERTO  = 4'hB,
    FIM_ERRO    = 4'hC,
    FIM_TIMEOUT = 4'hD
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_r;
    logic conta_r;
    logic registra_r;
    logic mostra_led;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  // Only the timed states let the cycle timer advance.
  function automatic logic timer_ativo(estado_t s);
    return (s == MOSTRA) || (s == APAGA) || (s == ESPERA);
  endfunction

endpackage

// File: rtl/unidade_controle_exp6_if.sv
// rtl/unidade_controle_exp6_if.sv - status/command bundle between datapath and control unit
interface unidade_controle_exp6_if;

  logic       jogar;
  logic       tem_jogada;
  logic       igual_jogada;
  logic       fim_rodada;
  logic       fim_seq;
  logic       zera_e;
  logic       conta_e;
  logic       zera_r;
  logic       conta_r;
  logic       registra_r;
  logic       mostra_led;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    output jogar, tem_jogada, igual_jogada, fim_rodada, fim_seq,
    input  zera_e, conta_e, zera_r, conta_r, registra_r, mostra_led,
    input  pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport slave (
    input  jogar, tem_jogada, igual_jogada, fim_rodada, fim_seq,
    output zera_e, conta_e, zera_r, conta_r, registra_r, mostra_led,
    output pronto, ganhou, perdeu, db_timeout, db_estado
  );

endinterface

// File: rtl/unidade_controle_exp6_temporizador_ciclos.sv
// rtl/unidade_controle_exp6_temporizador_ciclos.sv - saturating cycle timer with synchronous clear
module temporizador_ciclos
  import unidade_controle_exp6_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Saturates at all-ones so a stalled state never sees the count wrap back to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/unidade_controle_exp6.sv
// rtl/unidade_controle_exp6.sv - Moore control unit for the memory-sequence game
module unidade_controle_exp6
  import unidade_controle_exp6_pkg::*;
#(
  parameter int T_LED     = T_LED_DEF,
  parameter int T_APAGA   = T_APAGA_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_exp6_if.slave  bus
);

  localparam logic [TIMER_W-1:0] C_LED_END     = TIMER_W'(T_LED - 1);
  localparam logic [TIMER_W-1:0] C_APAGA_END   = TIMER_W'(T_APAGA - 1);
  localparam logic [TIMER_W-1:0] C_TIMEOUT_END = TIMER_W'(T_TIMEOUT - 1);

  estado_t              r_state;
  estado_t              w_next;
  saidas_t              w_out;
  logic [TIMER_W-1:0]   w_count;
  logic                 w_clear;
  logic                 w_enable;

  // Timer restarts on every transition, so it reads 0 on the first cycle of each state.
  assign w_clear  = (w_next != r_state);
  assign w_enable = timer_ativo(r_state);

  temporizador_ciclos #(
    .W (TIMER_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_count  (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= INICIAL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INICIAL:     if (bus.jogar) w_next = PREPARA;
      PREPARA:     w_next = MOSTRA;
      MOSTRA:      if (w_count == C_LED_END) w_next = APAGA;
      APAGA: begin
        if (w_count == C_APAGA_END) begin
          w_next = bus.fim_rodada ? ZERA_JOG : PROX_MOSTRA;
        end
      end
      PROX_MOSTRA: w_next = MOSTRA;
      ZERA_JOG:    w_next = ESPERA;
      // A press landing on the last allowed cycle still counts as a play.
      ESPERA: begin
        if (bus.tem_jogada) begin
          w_next = REGISTRA;
        end else if (w_count == C_TIMEOUT_END) begin
          w_next = FIM_TIMEOUT;
        end
      end
      REGISTRA:    w_next = COMPARA;
      COMPARA: begin
        if (!bus.igual_jogada) begin
          w_next = FIM_ERRO;
        end else if (!bus.fim_rodada) begin
          w_next = PROX_JOG;
        end else if (bus.fim_seq) begin
          w_next = FIM_ACERTO;
        end else begin
          w_next = PROX_RODADA;
        end
      end
      PROX_JOG:    w_next = ESPERA;
      PROX_RODADA: w_next = MOSTRA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (bus.jogar) w_next = PREPARA;
      end
      default:     w_next = INICIAL;
    endcase
  end

  always_comb begin
    w_out = '0;
    case (r_state)
      PREPARA: begin
        w_out.zera_e = 1'b1;
        w_out.zera_r = 1'b1;
      end
      MOSTRA:      w_out.mostra_led = 1'b1;
      PROX_MOSTRA: w_out.conta_e    = 1'b1;
      ZERA_JOG:    w_out.zera_e     = 1'b1;
      REGISTRA:    w_out.registra_r = 1'b1;
      PROX_JOG:    w_out.conta_e    = 1'b1;
      PROX_RODADA: begin
        w_out.conta_r = 1'b1;
        w_out.zera_e  = 1'b1;
      end
      FIM_ACERTO: begin
        w_out.pronto = 1'b1;
        w_out.ganhou = 1'b1;
      end
      FIM_ERRO: begin
        w_out.pronto = 1'b1;
        w_out.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        w_out.pronto     = 1'b1;
        w_out.perdeu     = 1'b1;
        w_out.db_timeout = 1'b1;
      end
      default:     w_out = '0;
    endcase
  end

  assign bus.zera_e     = w_out.zera_e;
  assign bus.conta_e    = w_out.conta_e;
  assign bus.zera_r     = w_out.zera_r;
  assign bus.conta_r    = w_out.conta_r;
  assign bus.registra_r = w_out.registra_r;
  assign bus.mostra_led = w_out.mostra_led;
  assign bus.pronto     = w_out.pronto;
  assign bus.ganhou     = w_out.ganhou;
  assign bus.perdeu     = w_out.perdeu;
  assign bus.db_timeout = w_out.db_timeout;
  assign bus.db_estado  = r_state;

endmodule

// File: doc/unidade_controle_exp6.md
UNIDADE_CONTROLE_EXP6 -- requirements
Module: unidade_controle_exp6

Interface
REQ-001 The block SHALL have parameter T_LED, default 500, meaning clock cycles one sequence LED stays lit (0.5 s at 1 kHz).
REQ-002 The block SHALL have parameter T_APAGA, default 250, meaning clock cycles of dark gap between shown LEDs.
REQ-003 The block SHALL have parameter T_TIMEOUT, default 5000, meaning cycles allowed between plays before the game is lost.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with these ports:
 clock  in  1  system clock, rising edge
 reset  in  1  asynchronous, active-low
 jogar  in  1  level; starts or restarts a game
 tem_jogada  in  1  one-cycle pulse from the datapath edge detector: a button was pressed
 igual_jogada  in  1  registered play equals the memory word at the current address
 fim_rodada  in  1  address counter equals round counter
 fim_seq  in  1  round counter at last round (15)
 zera_e  out  1  clear address counter
 conta_e  out  1  increment address counter
 zera_r  out  1  clear round counter
 conta_r  out  1  increment round counter
 registra_r  out  1  load play register from botoes
 mostra_led  out  1  drive leds from memory word
 pronto  out  1  game finished
 ganhou  out  1  game won
 perdeu  out  1  game lost (error or timeout)
 db_timeout  out  1  loss caused by timeout
 db_estado  out  4  current state code

Function
REQ-005 The FSM SHALL be Moore; all outputs SHALL decode from the state register only.
REQ-006 State codes SHALL be: INICIAL 0, PREPARA 1, MOSTRA 2, APAGA 3, PROX_MOSTRA 4, ZERA_JOG 5, ESPERA 6, REGISTRA 7, COMPARA 8, PROX_JOG 9, PROX_RODADA A, FIM_ACERTO B, FIM_ERRO C, FIM_TIMEOUT D; codes E/F SHALL go to INICIAL.
REQ-007 INICIAL SHALL stay until jogar=1, then go to PREPARA; all outputs 0.
REQ-008 PREPARA SHALL assert zera_e and zera_r for one cycle and then go to MOSTRA.
REQ-009 MOSTRA SHALL assert mostra_led for exactly T_LED cycles, then go to APAGA.
REQ-010 APAGA SHALL last exactly T_APAGA cycles, then go to ZERA_JOG if fim_rodada=1, else to PROX_MOSTRA.
REQ-011 PROX_MOSTRA SHALL assert conta_e for one cycle, then go to MOSTRA.
REQ-012 ZERA_JOG SHALL assert zera_e for one cycle, then go to ESPERA.
REQ-013 In ESPERA the cycle timer SHALL count. tem_jogada=1 SHALL go to REGISTRA. If the timer reaches T_TIMEOUT-1 with tem_jogada=0, the FSM SHALL go to FIM_TIMEOUT. If both occur in the same cycle, the play SHALL win.
REQ-014 REGISTRA SHALL assert registra_r for one cycle, then go to COMPARA.
REQ-015 COMPARA SHALL go to FIM_ERRO if igual_jogada=0; to PROX_JOG if fim_rodada=0; to FIM_ACERTO if fim_seq=1; otherwise to PROX_RODADA.
REQ-016 PROX_JOG SHALL assert conta_e for one cycle, then go to ESPERA.
REQ-017 PROX_RODADA SHALL assert conta_r and zera_e for one cycle, then go to MOSTRA.
REQ-018 The terminal states SHALL assert pronto=1, with ganhou=1 in FIM_ACERTO, perdeu=1 in FIM_ERRO, and perdeu=1 plus db_timeout=1 in FIM_TIMEOUT. Each terminal state SHALL hold until jogar=1, then go to PREPARA.
REQ-019 The timer SHALL be 16 bits, SHALL clear on every state change, SHALL count only in MOSTRA, APAGA and ESPERA, and SHALL never wrap.
REQ-020 jogar SHALL be ignored outside INICIAL and the terminal states.

Reset
REQ-021 reset=0 SHALL asynchronously force INICIAL, timer=0 and all outputs 0, including in mid-display and mid-play.
REQ-022 After reset is released, the first transition SHALL occur on a later rising edge of clock.

Structure
REQ-023 State codes and default timing constants SHALL live in a shared package used by the control unit, the datapath and the benches.
REQ-024 The cycle timer SHALL be one sub-module, temporizador_ciclos, with clear, enable and count ports.

Verification (benches use T_LED=4, T_APAGA=2, T_TIMEOUT=20)
REQ-025 Bench: reset, then jogar=1 for 1 cycle -> db_estado sequence 1,2 (4 cycles),3 (2 cycles),5,6, with mostra_led high exactly 4 cycles.
REQ-026 Bench: round 0, tem_jogada pulse with igual_jogada=1, fim_rodada=1, fim_seq=0 -> states 7,8,A,2, with conta_r high exactly 1 cycle.
REQ-027 Bench: in ESPERA, igual_jogada=0 on compare -> state C, pronto=1, perdeu=1, ganhou=0, held until jogar.
REQ-028 Bench: in ESPERA, no tem_jogada for 20 cycles -> state D, db_timeout=1. Variant with tem_jogada on cycle 20 -> state 7.
REQ-029 Bench: fim_rodada=1, fim_seq=1 and igual_jogada=1 at COMPARA -> state B, ganhou=1. Then jogar=1 -> state 1.
REQ-030 Bench: reset=0 asserted mid-MOSTRA -> db_estado=0 and all outputs 0 before the next clock edge.
